// File: rtl/clk_div_sched.sv
// Runtime-programmable clock divider: one-cycle enable strobe plus square divided clock.
// Ratio changes are staged and applied only at a period boundary, so no period is truncated.
module clk_div_sched #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEF_DIV = 6,
  parameter int unsigned PER_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_val,
  output logic             div_busy,
  output logic             load_err,
  output logic             running,
  output logic             clk_en,
  output logic             clk_div,
  output logic [PER_W-1:0] periods
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEF_DIV);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   s_q, s_d;
  logic               stop_pend_q, stop_pend_d;
  logic [PER_W-1:0]   periods_q, periods_d;
  logic               load_err_q, load_err_d;
  logic               load_ok;
  logic               active;
  logic               boundary;

  // Legal ratios are 2 and above: any bit set above bit 0.
  assign load_ok  = (div_val[CNT_W-1:1] != '0);
  assign active   = (state_q != IDLE);
  assign boundary = active && (cnt_q == n_q - 1'b1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    s_d         = s_q;
    stop_pend_d = stop_pend_q;
    periods_d   = periods_q;
    load_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start && !stop) begin
          state_d   = RUN;
          periods_d = '0;
        end
        if (div_load) begin
          if (load_ok) n_d = div_val;
          else         load_err_d = 1'b1;
        end
      end
      default: begin
        if (boundary) begin
          cnt_d     = '0;
          periods_d = periods_q + 1'b1;
          if (state_q == PEND) begin
            n_d     = s_q;
            state_d = RUN;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end

        // A load sampled in a RUN boundary is staged for the following boundary.
        if (div_load) begin
          if (load_ok && state_q == RUN) begin
            s_d     = div_val;
            state_d = PEND;
          end else begin
            load_err_d = 1'b1;
          end
        end

        if (stop) stop_pend_d = 1'b1;
        if (boundary && stop_pend_q) begin
          state_d     = IDLE;
          stop_pend_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n_q         <= DEF_N;
      s_q         <= '0;
      stop_pend_q <= 1'b0;
      periods_q   <= '0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      s_q         <= s_d;
      stop_pend_q <= stop_pend_d;
      periods_q   <= periods_d;
      load_err_q  <= load_err_d;
    end
  end

  assign running  = active;
  assign div_busy = (state_q == PEND);
  assign clk_en   = boundary;
  assign clk_div  = active && (cnt_q < (n_q >> 1));
  assign load_err = load_err_q;
  assign periods  = periods_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched; PER_W is shortened to 4 so the period counter wrap is reachable.
module tb_clk_div_sched;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned PER_W = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic             div_load;
  logic [CNT_W-1:0] div_val;
  logic             div_busy;
  logic             load_err;
  logic             running;
  logic             clk_en;
  logic             clk_div;
  logic [PER_W-1:0] periods;

  int unsigned n_checks;
  int unsigned n_fail;

  clk_div_sched #(
    .CNT_W  (CNT_W),
    .DEF_DIV(6),
    .PER_W  (PER_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .div_load(div_load),
    .div_val (div_val),
    .div_busy(div_busy),
    .load_err(load_err),
    .running (running),
    .clk_en  (clk_en),
    .clk_div (clk_div),
    .periods (periods)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; outputs are sampled 1ns after the last edge.
  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Checks one full pattern of 'cycles' samples for ratio n, starting at cnt=0.
  task automatic check_pattern(input string name, input int unsigned n, input int unsigned cycles);
    logic exp_en, exp_div;
    for (int unsigned k = 0; k < cycles; k++) begin
      exp_en  = ((k % n) == n - 1);
      exp_div = ((k % n) < (n / 2));
      n_checks++;
      if (clk_en !== exp_en || clk_div !== exp_div || running !== 1'b1) begin
        n_fail++;
        $display("FAIL %s k=%0d: clk_en=%b clk_div=%b running=%b, expected %b %b 1",
                 name, k, clk_en, clk_div, running, exp_en, exp_div);
      end
      step(1);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    n_checks++;
    if ({running, div_busy, clk_en, clk_div, load_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000", {running, div_busy, clk_en, clk_div, load_err});
    end
    n_checks++;
    if (periods !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_periods: got %0d expected 0", periods);
    end
  endtask

  task automatic test_default_div;
    start = 1'b1;
    step(1);
    start = 1'b0;
    check_pattern("default_n6", 6, 60);
    n_checks++;
    if (periods !== 4'd10) begin
      n_fail++;
      $display("FAIL default_periods: got %0d expected 10", periods);
    end
  endtask

  task automatic test_reload;
    step(2);
    div_load = 1'b1; div_val = 8'd4;
    step(1);
    div_load = 1'b0;
    n_checks++;
    if (div_busy !== 1'b1 || clk_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_staged: busy=%b clk_en=%b expected 1 0", div_busy, clk_en);
    end
    div_load = 1'b1; div_val = 8'd9;
    step(1);
    div_load = 1'b0;
    n_checks++;
    if (load_err !== 1'b1 || div_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_load_err: load_err=%b busy=%b expected 1 1", load_err, div_busy);
    end
    step(1);
    n_checks++;
    if (load_err !== 1'b0 || clk_en !== 1'b1 || div_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL old_period_end: load_err=%b clk_en=%b busy=%b expected 0 1 1", load_err, clk_en, div_busy);
    end
    step(1);
    n_checks++;
    if (div_busy !== 1'b0 || periods !== 4'd11) begin
      n_fail++;
      $display("FAIL reload_applied: busy=%b periods=%0d expected 0 11", div_busy, periods);
    end
    check_pattern("new_n4", 4, 8);
    n_checks++;
    if (periods !== 4'd13) begin
      n_fail++;
      $display("FAIL n4_periods: got %0d expected 13", periods);
    end
  endtask

  task automatic test_idle_load;
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(2);
    n_checks++;
    if (clk_en !== 1'b1 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_boundary_n4: clk_en=%b running=%b expected 1 1", clk_en, running);
    end
    step(1);
    n_checks++;
    if (running !== 1'b0 || clk_div !== 1'b0 || periods !== 4'd14) begin
      n_fail++;
      $display("FAIL stopped_n4: running=%b clk_div=%b periods=%0d expected 0 0 14", running, clk_div, periods);
    end
    div_load = 1'b1; div_val = 8'd1;
    step(1);
    div_load = 1'b0;
    n_checks++;
    if (load_err !== 1'b1 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_illegal_load: load_err=%b running=%b expected 1 0", load_err, running);
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
    n_checks++;
    if (periods !== 4'd0 || load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_clear: periods=%0d load_err=%b expected 0 0", periods, load_err);
    end
    check_pattern("n_kept_4", 4, 8);
  endtask

  task automatic test_stop;
    div_load = 1'b1; div_val = 8'd5;
    step(1);
    div_load = 1'b0;
    step(3);
    check_pattern("n5_first", 5, 1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(2);
    n_checks++;
    if (clk_en !== 1'b1 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_boundary_n5: clk_en=%b running=%b expected 1 1", clk_en, running);
    end
    step(1);
    n_checks++;
    if (running !== 1'b0 || clk_div !== 1'b0 || clk_en !== 1'b0) begin
      n_fail++;
      $display("FAIL stopped_n5: running=%b clk_div=%b clk_en=%b expected 0 0 0", running, clk_div, clk_en);
    end
    start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    step(1);
    n_checks++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL start_stop_idle: running=%b expected 0", running);
    end
  endtask

  task automatic test_reset_mid;
    start = 1'b1;
    step(1);
    start = 1'b0;
    div_load = 1'b1; div_val = 8'd4;
    step(1);
    div_load = 1'b0;
    step(2);
    n_checks++;
    if (div_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_before_rst: busy=%b expected 1", div_busy);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_checks++;
    if ({running, div_busy, clk_en, clk_div, load_err} !== 5'b0 || periods !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_reset: outs=%b periods=%0d expected 00000 0",
               {running, div_busy, clk_en, clk_div, load_err}, periods);
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
    check_pattern("after_rst_n6", 6, 12);
    n_checks++;
    if (periods !== 4'd2) begin
      n_fail++;
      $display("FAIL after_rst_periods: got %0d expected 2", periods);
    end
  endtask

  task automatic test_odd_and_wrap;
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(5);
    div_load = 1'b1; div_val = 8'd3;
    step(1);
    div_load = 1'b0;
    n_checks++;
    if (running !== 1'b0 || load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_for_n3: running=%b load_err=%b expected 0 0", running, load_err);
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
    check_pattern("odd_n3", 3, 9);
    n_checks++;
    if (periods !== 4'd3) begin
      n_fail++;
      $display("FAIL n3_periods: got %0d expected 3", periods);
    end
    step(36);
    n_checks++;
    if (periods !== 4'd15) begin
      n_fail++;
      $display("FAIL periods_max: got %0d expected 15", periods);
    end
    step(3);
    n_checks++;
    if (periods !== 4'd0) begin
      n_fail++;
      $display("FAIL periods_wrap: got %0d expected 0", periods);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    div_load = 1'b0;
    div_val  = '0;
    test_reset();
    test_default_div();
    test_reload();
    test_idle_load();
    test_stop();
    test_reset_mid();
    test_odd_and_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
